// File: rtl/rede_float_core_if.sv
//==============================================================================
// Module      : rede_float_core_if
// Description : Sample / result / strobe bundle between a neuron core and its
//               multicore wrapper. The core drives the master side.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rede_float_core_if;
  logic signed [18:0] io_in;   // shared input sample bus
  logic signed [27:0] io_out;  // result register
  logic        [3:0]  req_in;  // input request, bit0 = input port 0
  logic        [3:0]  out_en;  // output strobe, bit0 = output port 0

  modport master (input io_in, output io_out, output req_in, output out_en);
  modport slave  (output io_in, input io_out, input req_in, input out_en);
endinterface

`default_nettype wire

// File: rtl/rede_float_core.sv
//==============================================================================
// Module      : rede_float_core
// Description : Fixed-point neuron. Requests N_IN samples one at a time,
//               multiply-accumulates them against built-in weights, then adds
//               a bias, shifts arithmetically, saturates to 28 bits and
//               optionally applies ReLU. One result per frame, frames run
//               back-to-back.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rede_float_core #(
  parameter int                     N_IN    = 4,
  parameter int                     W_W     = 9,
  parameter logic [N_IN*W_W-1:0]    WEIGHTS = {N_IN{{{(W_W-1){1'b0}}, 1'b1}}},
  parameter logic signed [27:0]     BIAS    = 28'sd0,
  parameter int                     SHIFT   = 0,
  parameter int                     ACT     = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,    // asynchronous, active low
  rede_float_core_if.master bus
);

  // Accumulator is wide enough that N_IN full-scale products cannot wrap.
  localparam int ACC_W = 19 + W_W + $clog2(N_IN) + 1;
  localparam int SUM_W = ((ACC_W > 28) ? ACC_W : 28) + 1;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [SUM_W-1:0] C_MAX = SUM_W'(134217727);
  localparam logic signed [SUM_W-1:0] C_MIN = ~C_MAX;   // -2^27

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_MAC  = 3'd2,
    S_ACT  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [27:0]        r_out;
  logic                      r_req;
  logic                      r_oe;

  logic signed [W_W-1:0]     w_wt [N_IN];
  logic signed [W_W-1:0]     w_weight;
  logic signed [19+W_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_mac;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [SUM_W-1:0]   w_shift;
  logic signed [27:0]        w_sat;
  logic signed [27:0]        w_act;

  // Unpack the weight vector into an indexable table.
  for (genvar g = 0; g < N_IN; g++) begin : g_wt
    assign w_wt[g] = $signed(WEIGHTS[g*W_W +: W_W]);
  end

  assign w_weight = w_wt[r_idx];
  assign w_prod   = bus.io_in * w_weight;
  assign w_mac    = r_acc + ACC_W'(w_prod);

  // Bias, floor shift, clip to 28 bits, optional ReLU.
  assign w_sum   = SUM_W'(r_acc) + SUM_W'(BIAS);
  assign w_shift = w_sum >>> SHIFT;
  assign w_sat   = (w_shift > C_MAX) ? 28'sh7FFFFFF :
                   (w_shift < C_MIN) ? 28'sh8000000 : w_shift[27:0];
  assign w_act   = ((ACT == 1) && w_sat[27]) ? 28'sd0 : w_sat;

  // Frame sequencer; strobes are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_req   <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          r_req   <= 1'b0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= w_mac;
          if (r_idx == IDX_W'(N_IN - 1)) begin
            r_state <= S_ACT;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_ACT: begin
          r_out   <= w_act;
          r_acc   <= '0;
          r_idx   <= '0;
          r_state <= S_OUT;
          r_oe    <= 1'b1;
        end
        S_OUT: begin
          r_oe    <= 1'b0;
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_out = r_out;
  assign bus.req_in = {3'b000, r_req};
  assign bus.out_en = {3'b000, r_oe};

endmodule

`default_nettype wire

// File: tb/tb_rede_float_core.sv
//==============================================================================
// Module      : tb_rede_float_core
// Description : Four differently parameterised cores driven with directed
//               frames; expected results queued at issue and checked by a
//               monitor whenever a core strobes out_en.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rede_float_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstv  [4];
  logic signed [18:0] din   [4];
  logic [3:0]         reqv  [4];
  logic [3:0]         oev   [4];
  logic signed [27:0] out_b [4];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic signed [27:0] q0[$], q1[$], q2[$], q3[$];

  rede_float_core_if if0 ();
  rede_float_core_if if1 ();
  rede_float_core_if if2 ();
  rede_float_core_if if3 ();

  assign if0.io_in = din[0];
  assign if1.io_in = din[1];
  assign if2.io_in = din[2];
  assign if3.io_in = din[3];
  assign reqv[0] = if0.req_in;  assign oev[0] = if0.out_en;  assign out_b[0] = if0.io_out;
  assign reqv[1] = if1.req_in;  assign oev[1] = if1.out_en;  assign out_b[1] = if1.io_out;
  assign reqv[2] = if2.req_in;  assign oev[2] = if2.out_en;  assign out_b[2] = if2.io_out;
  assign reqv[3] = if3.req_in;  assign oev[3] = if3.out_en;  assign out_b[3] = if3.io_out;

  rede_float_core u0 (.clk(clk), .rst(rstv[0]), .bus(if0));
  rede_float_core #(.WEIGHTS({4{9'sd255}})) u1 (.clk(clk), .rst(rstv[1]), .bus(if1));
  rede_float_core #(.ACT(1), .BIAS(28'sd3))  u2 (.clk(clk), .rst(rstv[2]), .bus(if2));
  rede_float_core #(.SHIFT(2))               u3 (.clk(clk), .rst(rstv[3]), .bus(if3));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[core %0d]: got %0d, expected %0d", name, k, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic signed [27:0] e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output logic signed [27:0] e, output bit got);
    got = 1'b1;
    e   = '0;
    case (k)
      0: if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
      1: if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
      2: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
      default: if (q3.size() > 0) e = q3.pop_front(); else got = 1'b0;
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  // Wait (bounded) for a request pulse, observed at the falling edge.
  task automatic wait_req(input int k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (reqv[k][0]) begin
        ok = 1'b1;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL req_timeout[core %0d]: got no req_in, expected a pulse", k);
  endtask

  task automatic drive_frame(input int k, input int a, input int b, input int c, input int d,
                             input logic signed [27:0] e);
    int v [4];
    bit ok;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    push_exp(k, e);
    for (int i = 0; i < 4; i++) begin
      wait_req(k, ok);
      if (!ok) return;
      din[k] = 19'(v[i]);
    end
  endtask

  // Let the last result come out, then park the core in reset.
  task automatic finish_core(input int k);
    for (int c = 0; c < 30 && qsize(k) != 0; c++) @(negedge clk);
    check("drain", k, qsize(k), 0);
    rstv[k] = 1'b0;
  endtask

  // Core 0 bookkeeping: frame latency, first request after release, io_out hold.
  int                 req_cnt = 0;
  int                 start_cyc = 0;
  int                 rel_cyc = 0;
  bit                 first_pend = 1'b0;
  logic signed [27:0] hold = '0;

  // Monitor: scoreboard pops on out_en plus per-cycle protocol checks.
  always @(negedge clk) begin
    logic signed [27:0] e;
    bit got;
    for (int k = 0; k < 4; k++) begin
      if (rstv[k]) begin
        check("req_oe_excl", k, longint'(reqv[k][0] & oev[k][0]), 0);
        check("upper_bits", k, longint'({reqv[k][3:1], oev[k][3:1]}), 0);
      end
      if (oev[k][0]) begin
        pop_exp(k, e, got);
        if (!got) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out[core %0d]: got out_en with io_out=%0d, expected none", k, out_b[k]);
        end else begin
          check("result", k, out_b[k], e);
        end
      end
    end
    if (!rstv[0]) begin
      first_pend = 1'b1;
      rel_cyc    = cyc;
      req_cnt    = 0;
      hold       = '0;
    end else begin
      if (reqv[0][0]) begin
        if (first_pend) begin
          check("first_req_delay", 0, longint'((cyc - rel_cyc >= 1) && (cyc - rel_cyc <= 2)), 1);
          first_pend = 1'b0;
        end
        if (req_cnt == 0) start_cyc = cyc;
        req_cnt = (req_cnt + 1) % 4;
      end
      if (oev[0][0]) begin
        check("frame_latency", 0, cyc - start_cyc, 9);
        hold = out_b[0];
      end else begin
        check("io_out_hold", 0, out_b[0], hold);
      end
    end
  end

  initial begin
    bit ok;
    for (int k = 0; k < 4; k++) begin
      rstv[k] = 1'b0;
      din[k]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_io_out", k, out_b[k], 0);
      check("rst_req_in", k, reqv[k], 0);
      check("rst_out_en", k, oev[k], 0);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) rstv[k] = 1'b1;

    fork
      begin
        drive_frame(0, 100, 200, 300, 400, 28'sd1000);
        drive_frame(0, -262144, -262144, -262144, -262144, -28'sd1048576);
        drive_frame(0, 7, 8, 9, 10, 28'sd34);
        // Abort a frame during its second MAC cycle.
        wait_req(0, ok);
        din[0] = 19'sd1000;
        wait_req(0, ok);
        din[0] = 19'sd2000;
        @(negedge clk);
        rstv[0] = 1'b0;
        #1;
        check("midrst_req_in", 0, reqv[0], 0);
        check("midrst_out_en", 0, oev[0], 0);
        check("midrst_io_out", 0, out_b[0], 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rstv[0] = 1'b1;
        drive_frame(0, 1, 2, 3, 4, 28'sd10);
        finish_core(0);
      end
      begin
        drive_frame(1, 262143, 262143, 262143, 262143, 28'sd134217727);
        drive_frame(1, -262144, -262144, -262144, -262144, -28'sd134217728);
        drive_frame(1, 1000, 1000, 1000, 1000, 28'sd1020000);
        finish_core(1);
      end
      begin
        drive_frame(2, -5, -5, -5, -5, 28'sd0);
        drive_frame(2, 5, 5, 5, 5, 28'sd23);
        drive_frame(2, -1, 0, 0, 0, 28'sd2);
        finish_core(2);
      end
      begin
        drive_frame(3, -3, 0, 0, 0, -28'sd1);
        drive_frame(3, -5, 0, 0, 0, -28'sd2);
        drive_frame(3, 8, 4, 0, 0, 28'sd3);
        finish_core(3);
      end
    join

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
